// File: rtl/krnl_vadd_rtl_adder_arb_pkg.sv
// Shared types for the vadd adder arbiter.
// FSM state encoding and the requester-ID width helper.
package krnl_vadd_rtl_adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    XFER = 2'd2
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/krnl_vadd_rtl_adder_arbiter_if.sv
// AXI4-Stream bundle from the arbiter to the adder's s_axis,
// carrying the requester ID alongside each beat.
interface krnl_vadd_rtl_adder_arbiter_if #(
  parameter int DW = 512,
  parameter int IW = 2
);
  localparam int KW = DW / 8;

  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic [IW-1:0] tid;

  modport master (
    output tvalid, tdata, tkeep, tlast, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast, tid,
    output tready
  );

endinterface

// File: rtl/krnl_vadd_rtl_axis_skid.sv
// Two-entry register slice for the arbiter output path,
// used when KRNL_VADD_RTL_ADDER_ARB_OUT_REG_EN is defined.
module krnl_vadd_rtl_axis_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         push;
  logic         pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign empty     = (cnt_q == 2'd0);
  assign out_data  = mem_q[rd_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= in_data;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/krnl_vadd_rtl_adder_arbiter.sv
// Packet round-robin arbiter sharing one vadd adder between requesters.
// KRNL_VADD_RTL_ADDER_ARB_OUT_REG_EN adds a registered output skid buffer.
module krnl_vadd_rtl_adder_arbiter
  import krnl_vadd_rtl_adder_arb_pkg::*;
#(
  parameter int C_NUM_REQ          = 4,
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic [C_NUM_REQ*C_ADDER_BIT_WIDTH-1:0] ctrl_constant_table,
  input  logic [C_NUM_REQ-1:0] s_axis_tvalid,
  output logic [C_NUM_REQ-1:0] s_axis_tready,
  input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_NUM_REQ-1:0] s_axis_tlast,
  krnl_vadd_rtl_adder_arbiter_if.master m_axis,
  output logic [C_ADDER_BIT_WIDTH-1:0] adder_ctrl_constant,
  output logic busy
);

  localparam int N  = C_NUM_REQ;
  localparam int DW = C_AXIS_TDATA_WIDTH;
  localparam int KW = DW / 8;
  localparam int AW = C_ADDER_BIT_WIDTH;
  localparam int IW = id_width(N);

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] last_q;
  logic [IW-1:0] pick;
  logic          sel_valid;
  logic          sel_last;
  logic [DW-1:0] sel_data;
  logic [KW-1:0] sel_keep;
  logic          in_valid;
  logic          path_ready;
  logic          buf_empty;
  logic          start;
  logic          done;

  // First valid requester after the last grant, wrapping.
  function automatic logic [IW-1:0] rr_pick(
    input logic [N-1:0]  v,
    input logic [IW-1:0] last
  );
    logic [IW-1:0] idx;
    rr_pick = last;
    for (int i = N; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % N);
      if (v[idx]) rr_pick = idx;
    end
  endfunction

  assign pick      = rr_pick(s_axis_tvalid, last_q);
  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign sel_data  = s_axis_tdata[int'(grant_q)*DW +: DW];
  assign sel_keep  = s_axis_tkeep[int'(grant_q)*KW +: KW];

  assign start = (state_q == IDLE)
               & (|s_axis_tvalid)
               & buf_empty;
  assign done  = in_valid & path_ready & sel_last;
  assign busy  = (state_q != IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM:     state_d = XFER;
      XFER:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    in_valid      = 1'b0;
    if (state_q == XFER) begin
      s_axis_tready[grant_q] = path_ready;
      in_valid               = sel_valid;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_q             <= '0;
      last_q              <= IW'(N - 1);
      adder_ctrl_constant <= '0;
    end else if (start) begin
      grant_q             <= pick;
      last_q              <= pick;
      adder_ctrl_constant <=
        ctrl_constant_table[int'(pick)*AW +: AW];
    end
  end

`ifdef KRNL_VADD_RTL_ADDER_ARB_OUT_REG_EN
  localparam int PW = IW + 1 + KW + DW;

  logic [PW-1:0] out_data;

  krnl_vadd_rtl_axis_skid #(.W(PW)) u_skid (
    .clk       (aclk),
    .rst_n     (aresetn),
    .in_valid  (in_valid),
    .in_ready  (path_ready),
    .in_data   ({grant_q, sel_last, sel_keep, sel_data}),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready),
    .out_data  (out_data),
    .empty     (buf_empty)
  );

  assign {m_axis.tid, m_axis.tlast,
          m_axis.tkeep, m_axis.tdata} = out_data;
`else
  assign buf_empty     = 1'b1;
  assign path_ready    = m_axis.tready;
  assign m_axis.tvalid = in_valid;
  assign m_axis.tdata  = sel_data;
  assign m_axis.tkeep  = sel_keep;
  assign m_axis.tlast  = sel_last;
  assign m_axis.tid    = grant_q;
`endif

endmodule

// File: tb/tb_krnl_vadd_rtl_adder_arbiter.sv
// Scoreboard bench for the vadd adder arbiter.
// Expected beats are queued at load time, a monitor checks m_axis.
module tb_krnl_vadd_rtl_adder_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int AW = 32;
  localparam int IW = 2;
`ifdef KRNL_VADD_RTL_ADDER_ARB_OUT_REG_EN
  localparam int GAP       = 4;
  localparam int STALL_MAX = 2;
`else
  localparam int GAP       = 3;
  localparam int STALL_MAX = 0;
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [N*AW-1:0] table_c = {32'd40, 32'd30, 32'd20, 32'd10};
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N-1:0]    s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [AW-1:0]   cst;
  logic            busy;

  krnl_vadd_rtl_adder_arbiter_if #(.DW(DW), .IW(IW)) m_axis ();

  krnl_vadd_rtl_adder_arbiter #(
    .C_NUM_REQ          (N),
    .C_AXIS_TDATA_WIDTH (DW),
    .C_ADDER_BIT_WIDTH  (AW)
  ) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .ctrl_constant_table (table_c),
    .s_axis_tvalid       (s_tvalid),
    .s_axis_tready       (s_tready),
    .s_axis_tdata        (s_tdata),
    .s_axis_tkeep        (s_tkeep),
    .s_axis_tlast        (s_tlast),
    .m_axis              (m_axis),
    .adder_ctrl_constant (cst),
    .busy                (busy)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] tid;
    logic [DW-1:0] data;
    logic          last;
    logic [AW-1:0] cst;
    logic [DW-1:0] sum;
  } exp_t;

  beat_t src_q [N][$];
  exp_t  exp_q [$];

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int acc_cnt = 0;
  int seg = 0;
  int cyc = 0;
  logic chk_gap = 1'b0;
  logic [N-1:0] gap = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic load(input int k, input int n, input int base,
                      input int step, input int nexp);
    beat_t b;
    exp_t  e;
    logic [31:0] v;
    logic [31:0] c;
    c = table_c[k*AW +: AW];
    for (int j = 0; j < n; j++) begin
      v = 32'(base + j * step);
      b.data = {v, v};
      b.last = (j == n - 1);
      src_q[k].push_back(b);
      if (j < nexp) begin
        e.tid  = IW'(k);
        e.data = b.data;
        e.last = b.last;
        e.cst  = c;
        e.sum  = {v + c, v + c};
        exp_q.push_back(e);
      end
    end
  endtask

  // Driver: present the head beat of each source queue.
  initial begin
    logic [N-1:0] acc;
    beat_t b;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tkeep  = '1;
    s_tlast  = '0;
    forever begin
      @(negedge aclk);
      acc = s_tvalid & s_tready;
      @(posedge aclk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k] && src_q[k].size() != 0) begin
          void'(src_q[k].pop_front());
          acc_cnt++;
        end
        if (src_q[k].size() != 0 && !gap[k]) begin
          b = src_q[k][0];
          s_tvalid[k] = 1'b1;
          s_tdata[k*DW +: DW] = b.data;
          s_tlast[k] = b.last;
        end else begin
          s_tvalid[k] = 1'b0;
          s_tlast[k]  = 1'b0;
        end
      end
    end
  end

  // Monitor: pop and compare on every m_axis handshake.
  initial begin
    exp_t e;
    logic [DW-1:0] sum_act;
    int last_cyc;
    int last_seg;
    logic prev_last;
    last_cyc  = -100;
    last_seg  = -1;
    prev_last = 1'b0;
    forever begin
      @(negedge aclk);
      if (aresetn && m_axis.tvalid && m_axis.tready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat tid=%0d data=%h required none",
                   m_axis.tid, m_axis.tdata);
        end else begin
          e = exp_q.pop_front();
          checks += 2;
          if (m_axis.tid !== e.tid || m_axis.tdata !== e.data ||
              m_axis.tlast !== e.last ||
              m_axis.tkeep !== {KW{1'b1}}) begin
            errors++;
            $display("FAIL beat got tid=%0d data=%h last=%b keep=%h required tid=%0d data=%h last=%b",
                     m_axis.tid, m_axis.tdata, m_axis.tlast,
                     m_axis.tkeep, e.tid, e.data, e.last);
          end
          sum_act = {m_axis.tdata[63:32] + cst,
                     m_axis.tdata[31:0] + cst};
          if (cst !== e.cst || sum_act !== e.sum) begin
            errors++;
            $display("FAIL adder_sum got const=%0d sum=%h required const=%0d sum=%h",
                     cst, sum_act, e.cst, e.sum);
          end
          if (chk_gap && prev_last && last_seg == seg) begin
            checks++;
            if (cyc - last_cyc != GAP) begin
              errors++;
              $display("FAIL packet_gap got %0d cycles required %0d",
                       cyc - last_cyc, GAP);
            end
          end
          prev_last = m_axis.tlast;
          last_cyc  = cyc;
          last_seg  = seg;
        end
      end
    end
  end

  task automatic tick;
    @(posedge aclk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d beats outstanding required 0",
               name, exp_q.size());
      exp_q.delete();
      for (int k = 0; k < N; k++) src_q[k].delete();
    end
  endtask

  task automatic wait_hs(input int target, input int budget,
                         input string name);
    int n;
    n = 0;
    while (hs_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (hs_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout got %0d beats required %0d",
               name, hs_cnt, target);
    end
  endtask

  initial begin
    int a0;
    int n;
    m_axis.tready = 1'b1;
    aresetn = 1'b0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_const", 64'(cst), 64'd0);
    check("rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tid", 64'(m_axis.tid), 64'd0);
    aresetn = 1'b1;
    tick();

    // Round robin 0,1,2,3,0 with 2-beat packets
    seg = 1;
    chk_gap = 1'b1;
    load(0, 2, 32'h10, 1, 2);
    load(1, 2, 32'h20, 1, 2);
    load(2, 2, 32'h30, 1, 2);
    load(3, 2, 32'h40, 1, 2);
    load(0, 2, 32'h50, 1, 2);
    wait_drain(100, "rr_order");
    chk_gap = 1'b0;

    // Requester 2 alone, lanes of 5, constant 30
    seg = 2;
    load(2, 4, 5, 0, 4);
    n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    check("arm_busy", 64'(busy), 64'd1);
    check("arm_const", 64'(cst), 64'd30);
    check("arm_tready", 64'(s_tready), 64'd0);
    wait_drain(40, "single_req");
    check("const_hold", 64'(cst), 64'd30);

    // Requester 1 with valid gaps, requester 0 waiting
    seg = 3;
    load(1, 3, 32'h60, 1, 3);
    tick();
    tick();
    load(0, 1, 32'h70, 1, 1);
    for (int i = 0; i < 16; i++) begin
      gap[1] = (i % 3 == 1);
      tick();
      if (src_q[1].size() != 0)
        check("r0_ready_held", 64'(s_tready[0]), 64'd0);
    end
    gap = '0;
    wait_drain(40, "gaps");

    // Downstream stall during XFER
    seg = 4;
    a0 = hs_cnt;
    load(2, 4, 32'h80, 1, 4);
    wait_hs(a0 + 1, 20, "stall_start");
    m_axis.tready = 1'b0;
    a0 = acc_cnt;
    repeat (5) tick();
    check("stall_accepts",
          64'(acc_cnt - a0 <= STALL_MAX), 64'd1);
    m_axis.tready = 1'b1;
    wait_drain(40, "stall");

    // Reset on beat 2 of a 4-beat packet
    seg = 5;
    a0 = hs_cnt;
    load(1, 4, 32'h90, 1, 1);
    wait_hs(a0 + 1, 20, "reset_start");
    aresetn = 1'b0;
    #1;
    check("rst_mid_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_mid_tready", 64'(s_tready), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_const", 64'(cst), 64'd0);
    src_q[1].delete();
    tick();
    aresetn = 1'b1;
    tick();
    load(0, 1, 32'hA0, 1, 1);
    load(2, 1, 32'hB0, 1, 1);
    wait_drain(40, "post_reset");

    // Single-beat packets from requester 3 only
    seg = 6;
    chk_gap = 1'b1;
    load(3, 1, 32'hC0, 1, 1);
    load(3, 1, 32'hC1, 1, 1);
    load(3, 1, 32'hC2, 1, 1);
    wait_drain(40, "single_beat");
    chk_gap = 1'b0;

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
